// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorting network: one compare-exchange column per register stage,
// per-vector ascending/descending mode, sideband tag, and ready/valid backpressure.
module bitonic_sort_pipe #(
    parameter int DATA_W = 8,
    parameter int LOG2N  = 3,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [(2**LOG2N)*DATA_W-1:0]      in_data,
    input  logic                              in_desc,
    input  logic [TAG_W-1:0]                  in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [(2**LOG2N)*DATA_W-1:0]      out_data,
    output logic                              out_desc,
    output logic [TAG_W-1:0]                  out_tag
);

    localparam int N  = 2 ** LOG2N;
    localparam int S  = (LOG2N * (LOG2N + 32'sd1)) / 32'sd2;
    localparam int VW = N * DATA_W;

    function automatic logic elem_lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 32'sd0) begin
            return $signed(a) < $signed(b);
        end else begin
            return a < b;
        end
    endfunction

    // One column of the network: lane i pairs with i+j whenever bit j of i is clear.
    function automatic logic [VW-1:0] cas_column(input logic [VW-1:0] v, input logic desc,
                                                 input int k, input int j);
        logic [VW-1:0]     r;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        r = v;
        for (int i = 32'sd0; i < N; i++) begin
            if ((i & j) == 32'sd0) begin
                a = v[i*DATA_W +: DATA_W];
                b = v[(i+j)*DATA_W +: DATA_W];
                if (elem_lt(b, a)) begin
                    lo = b;
                    hi = a;
                end else begin
                    lo = a;
                    hi = b;
                end
                if (((i & k) == 32'sd0) ^ desc) begin
                    r[i*DATA_W +: DATA_W]     = lo;
                    r[(i+j)*DATA_W +: DATA_W] = hi;
                end else begin
                    r[i*DATA_W +: DATA_W]     = hi;
                    r[(i+j)*DATA_W +: DATA_W] = lo;
                end
            end
        end
        return r;
    endfunction

    // Element 0 of each chain is the input port; element s+1 is the register of stage s.
    logic [VW-1:0]    stage_data_s  [0:S];
    logic             stage_valid_s [0:S];
    logic             stage_desc_s  [0:S];
    logic [TAG_W-1:0] stage_tag_s   [0:S];
    logic             stall_s;

    assign stage_data_s[0]  = in_data;
    assign stage_valid_s[0] = in_valid;
    assign stage_desc_s[0]  = in_desc;
    assign stage_tag_s[0]   = in_tag;

    // Reset dominates the stall so the block reports ready while rst is held low.
    assign stall_s  = stage_valid_s[S] & ~out_ready & rst;
    assign in_ready = ~stall_s;

    assign out_valid = stage_valid_s[S];
    assign out_data  = stage_data_s[S];
    assign out_desc  = stage_desc_s[S];
    assign out_tag   = stage_tag_s[S];

    for (genvar p = 32'sd1; p <= LOG2N; p++) begin : g_merge
        for (genvar q = p; q >= 32'sd1; q--) begin : g_col
            localparam int STG = (p * (p - 32'sd1)) / 32'sd2 + (p - q);
            localparam int K   = 32'sd1 << p;
            localparam int J   = 32'sd1 << (q - 32'sd1);

            logic [VW-1:0]    col_s;
            logic [VW-1:0]    data_r;
            logic             valid_r;
            logic             desc_r;
            logic [TAG_W-1:0] tag_r;

            // Compare-exchange of the vector entering this stage, using that vector's own mode.
            always_comb begin
                col_s = cas_column(stage_data_s[STG], stage_desc_s[STG], K, J);
            end

            // Stage register: clears on reset, holds on stall, otherwise advances (bubbles included).
            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_r <= 1'b0;
                    data_r  <= '0;
                    desc_r  <= 1'b0;
                    tag_r   <= '0;
                end else if (!stall_s) begin
                    valid_r <= stage_valid_s[STG];
                    data_r  <= col_s;
                    desc_r  <= stage_desc_s[STG];
                    tag_r   <= stage_tag_s[STG];
                end else begin
                    valid_r <= valid_r;
                    data_r  <= data_r;
                    desc_r  <= desc_r;
                    tag_r   <= tag_r;
                end
            end

            assign stage_data_s[STG+1]  = data_r;
            assign stage_valid_s[STG+1] = valid_r;
            assign stage_desc_s[STG+1]  = desc_r;
            assign stage_tag_s[STG+1]   = tag_r;
        end
    end

endmodule
